dmap_cache: RTL and testbench

DMAP_CACHE -- requirements
Module: dmap_cache

---
 rtl/dcache_pkg.sv | 20 ++
 rtl/dcache_store.sv | 46 ++++
 rtl/dmap_cache.sv | 140 ++++++++++++++
 tb/tb_dmap_cache.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types and constants for the direct-mapped write-through data cache.
// Holds the controller state encoding and the address-split widths.
package dcache_pkg;

  localparam int ADDR_BITS      = 32;
  localparam int DEF_INDEX_BITS = 6;
  localparam int DEF_TAG_BITS   = ADDR_BITS - DEF_INDEX_BITS - 2;

  // Tag width for a given index width; the low two address bits select a byte in the word.
  function automatic int tag_bits(input int index_bits);
    return ADDR_BITS - index_bits - 2;
  endfunction

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WTHRU = 2'd2
  } state_t;

endpackage

// File: rtl/dcache_store.sv
// Line storage: valid/tag/data per line, combinational read, one synchronous write.
// Only the valid bits are reset; tag and data contents are don't-care until a line is valid.
module dcache_store
  import dcache_pkg::*;
#(
  parameter int INDEX_BITS = DEF_INDEX_BITS,
  parameter int TAG_BITS   = tag_bits(INDEX_BITS)
) (
  input  logic                  clk,
  input  logic                  clrn,
  input  logic [INDEX_BITS-1:0] rd_idx,
  output logic                  rd_valid,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic [31:0]           rd_data,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_idx,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [31:0]           wr_data
);

  localparam int LINES = 2 ** INDEX_BITS;

  logic [LINES-1:0]    valid_q;
  logic [TAG_BITS-1:0] tag_q  [LINES];
  logic [31:0]         data_q [LINES];

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/dmap_cache.sv
// Direct-mapped, write-through, no-write-allocate cache; read hits complete in the request cycle,
// misses and writes wait on memory m_ready. Define DCACHE_STATS_EN for hit/miss counter ports.
module dmap_cache
  import dcache_pkg::*;
#(
  parameter int INDEX_BITS = DEF_INDEX_BITS
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic [31:0] p_a,
  input  logic [31:0] p_din,
  input  logic        p_strobe,
  input  logic        p_rw,
  output logic [31:0] p_dout,
  output logic        p_ready,
  output logic [31:0] m_a,
  output logic [31:0] m_din,
  output logic        m_strobe,
  output logic        m_rw,
  input  logic [31:0] m_dout,
  input  logic        m_ready
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int TAG_BITS = tag_bits(INDEX_BITS);

  state_t state, next_state;

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0]   tag;
  logic                  line_valid;
  logic [TAG_BITS-1:0]   line_tag;
  logic [31:0]           line_data;
  logic                  hit;
  logic                  wr_en;
  logic [31:0]           wr_data;
  logic                  read_hit;
  logic                  fill_done;
  logic                  addr_lsb_unused;

  assign idx             = p_a[INDEX_BITS+1:2];
  assign tag             = p_a[31:INDEX_BITS+2];
  assign addr_lsb_unused = ^p_a[1:0];
  assign hit             = line_valid && (line_tag == tag);

  // Memory sees the CPU request directly; the CPU holds it stable until p_ready.
  assign m_a   = p_a;
  assign m_din = p_din;

  dcache_store #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_store (
    .clk      (clk),
    .clrn     (clrn),
    .rd_idx   (idx),
    .rd_valid (line_valid),
    .rd_tag   (line_tag),
    .rd_data  (line_data),
    .wr_en    (wr_en),
    .wr_idx   (idx),
    .wr_tag   (tag),
    .wr_data  (wr_data)
  );

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    p_ready    = 1'b0;
    p_dout     = '0;
    m_strobe   = 1'b0;
    m_rw       = 1'b0;
    wr_en      = 1'b0;
    wr_data    = m_dout;
    read_hit   = 1'b0;
    fill_done  = 1'b0;
    case (state)
      IDLE: begin
        if (p_strobe) begin
          if (p_rw) begin
            next_state = WTHRU;
          end else if (hit) begin
            p_ready  = 1'b1;
            p_dout   = line_data;
            read_hit = 1'b1;
          end else begin
            next_state = FILL;
          end
        end
      end
      FILL: begin
        m_strobe = 1'b1;
        if (m_ready) begin
          // Fill data is bypassed to the CPU in the same cycle it is written into the line.
          p_ready    = p_strobe;
          p_dout     = m_dout;
          wr_en      = 1'b1;
          wr_data    = m_dout;
          fill_done  = 1'b1;
          next_state = IDLE;
        end
      end
      WTHRU: begin
        m_strobe = 1'b1;
        m_rw     = 1'b1;
        if (m_ready) begin
          p_ready    = p_strobe;
          wr_en      = hit;
          wr_data    = p_din;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (read_hit) hit_count <= hit_count + 32'd1;
      if (fill_done) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmap_cache.sv
// Scoreboarded bench for dmap_cache with a slow RAM responder and an address-level cache model.
module tb_dmap_cache;

  logic        clk = 1'b0;
  logic        clrn;
  logic [31:0] p_a, p_din, p_dout, m_a, m_din, m_dout;
  logic        p_strobe, p_rw, p_ready, m_strobe, m_rw, m_ready;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  dmap_cache #(.INDEX_BITS(6)) dut (
    .clk      (clk),
    .clrn     (clrn),
    .p_a      (p_a),
    .p_din    (p_din),
    .p_strobe (p_strobe),
    .p_rw     (p_rw),
    .p_dout   (p_dout),
    .p_ready  (p_ready),
    .m_a      (m_a),
    .m_din    (m_din),
    .m_strobe (m_strobe),
    .m_rw     (m_rw),
    .m_dout   (m_dout),
    .m_ready  (m_ready)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_write;
    logic        hit;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] dout;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          fails  = 0;
  logic [31:0] ram     [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] ref_line [int];
  int          ref_hits = 0;
  int          ref_misses = 0;

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a == 32'h0) ? 32'h15 : ((a * 32'h9E37_79B1) ^ 32'h0BAD_F00D);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Slow RAM: answers each strobe after 1..3 wait cycles with a one-cycle m_ready.
  initial begin
    int cnt;
    int lat;
    cnt = 0;
    lat = 1;
    m_ready = 1'b0;
    m_dout  = '0;
    forever begin
      @(posedge clk);
      #2;
      if (!clrn || m_ready || !m_strobe) begin
        m_ready = 1'b0;
        cnt = 0;
      end else begin
        if (cnt == 0) lat = $urandom_range(1, 3);
        if (cnt >= lat) begin
          if (m_rw) ram[m_a] = m_din;
          else m_dout = ram.exists(m_a) ? ram[m_a] : init_val(m_a);
          m_ready = 1'b1;
        end else begin
          cnt++;
        end
      end
    end
  end

  // Monitor: compares every CPU completion against the oldest expected response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!p_strobe) check("ready_without_strobe", {31'b0, p_ready}, 32'h0);
      if (p_ready) begin
        if (sb.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_ready: got p_ready=1 expected no pending request at %0t", $time);
        end else begin
          e = sb.pop_front();
          check("m_strobe_at_ready", {31'b0, m_strobe}, {31'b0, !e.hit});
          if (m_strobe) begin
            check("m_rw", {31'b0, m_rw}, {31'b0, e.is_write});
            check("m_a", m_a, e.addr);
            if (e.is_write) check("m_din", m_din, e.din);
          end
          if (!e.is_write) check("p_dout", p_dout, e.dout);
        end
      end
    end
  end

  task automatic model_reset();
    ref_line.delete();
    ref_hits = 0;
    ref_misses = 0;
  endtask

  task automatic do_req(input logic [31:0] a, input logic rw, input logic [31:0] d);
    exp_t e;
    int   idx;
    int   n;
    idx = int'((a >> 2) & 32'h3F);
    if (!ref_mem.exists(a)) ref_mem[a] = init_val(a);
    e.is_write = rw;
    e.addr = a;
    e.din = d;
    e.dout = '0;
    e.hit = 1'b0;
    if (rw) begin
      ref_mem[a] = d;
    end else begin
      e.dout = ref_mem[a];
      e.hit = ref_line.exists(idx) && (ref_line[idx] == a);
      if (e.hit) ref_hits++;
      else begin
        ref_misses++;
        ref_line[idx] = a;
      end
    end
    sb.push_back(e);
    p_a = a;
    p_din = d;
    p_rw = rw;
    p_strobe = 1'b1;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (p_ready) break;
      n++;
      if (n > 40) begin
        checks++;
        fails++;
        $display("FAIL req_timeout: got no p_ready for addr %h expected one within 40 cycles", a);
        break;
      end
    end
    @(posedge clk);
    #1;
    p_strobe = 1'b0;
`ifdef DCACHE_STATS_EN
    check("hit_count", hit_count, ref_hits);
    check("miss_count", miss_count, ref_misses);
`endif
  endtask

  initial begin
    clrn = 1'b0;
    p_a = '0;
    p_din = '0;
    p_rw = 1'b0;
    p_strobe = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_p_ready", {31'b0, p_ready}, 32'h0);
    check("rst_m_strobe", {31'b0, m_strobe}, 32'h0);
    check("rst_m_rw", {31'b0, m_rw}, 32'h0);
    check("rst_p_dout", p_dout, 32'h0);
    clrn = 1'b1;
    @(posedge clk);
    #1;

    do_req(32'h0000_0000, 1'b0, 32'h0);
    do_req(32'h0000_0000, 1'b0, 32'h0);
    do_req(32'h0000_0000, 1'b1, 32'hDEAD_BEEF);
    do_req(32'h0000_0000, 1'b0, 32'h0);
    do_req(32'h0000_0104, 1'b1, 32'h1234_5678);
    do_req(32'h0000_0104, 1'b0, 32'h0);
    do_req(32'h0000_0100, 1'b0, 32'h0);
    do_req(32'h0000_0000, 1'b0, 32'h0);
    do_req(32'h0000_0000, 1'b0, 32'h0);

    // Reset in the middle of a fill: no completion expected, strobe must drop at once.
    p_a = 32'h0000_0200;
    p_rw = 1'b0;
    p_strobe = 1'b1;
    @(posedge clk);
    #1;
    check("fill_m_strobe", {31'b0, m_strobe}, 32'h1);
    check("fill_m_rw", {31'b0, m_rw}, 32'h0);
    #2;
    clrn = 1'b0;
    #1;
    check("abort_m_strobe", {31'b0, m_strobe}, 32'h0);
    check("abort_p_ready", {31'b0, p_ready}, 32'h0);
    check("abort_p_dout", p_dout, 32'h0);
    p_strobe = 1'b0;
    @(posedge clk);
    #3;
    clrn = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    do_req(32'h0000_0200, 1'b0, 32'h0);
    do_req(32'h0000_0000, 1'b0, 32'h0);

    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 2);
      do_req(a, ($urandom_range(0, 2) == 0), $urandom);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
